// File: rtl/mil_esc_stream_decoder_pkg.sv
// Shared MIL-STD-1553 word typing for the memory-to-MIL path: word types,
// escape codes, FSM encodings and the default escape prefix.
package mil_esc_stream_decoder_pkg;

    typedef enum logic [1:0] {
        WERROR   = 2'd0,
        WCOMMAND = 2'd1,
        WSTATUS  = 2'd2,
        WDATA    = 2'd3
    } word_type_e;

    typedef enum logic [1:0] {
        ESC_CODE_WERROR   = 2'd0,
        ESC_CODE_WCOMMAND = 2'd1,
        ESC_CODE_WSTATUS  = 2'd2,
        ESC_CODE_WDATA    = 2'd3
    } esc_code_e;

    typedef enum logic [1:0] {
        IN_IDLE    = 2'd0,
        IN_ESC_ACK = 2'd1,
        IN_ESC     = 2'd2,
        IN_PUSH    = 2'd3
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_WAIT = 2'd2
    } out_state_e;

    localparam logic [15:0] ESC_BASE_DEFAULT = 16'hFFA0;

    // Map the low two bits of an escape word onto the MIL word type.
    function automatic word_type_e esc_to_type(input esc_code_e code);
        word_type_e t;
        case (code)
            ESC_CODE_WERROR:   t = WERROR;
            ESC_CODE_WCOMMAND: t = WCOMMAND;
            ESC_CODE_WSTATUS:  t = WSTATUS;
            default:           t = WDATA;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mil_word_fifo.sv
// Synchronous FIFO of typed MIL words. Full/empty come from the occupancy
// count only; the power-of-two pointers simply wrap.
module mil_word_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    // A push at full is refused even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/mil_esc_stream_decoder.sv
// Escape-stream to MIL word decoder with a word FIFO between the stream
// side and the MIL transmitter, plus an escape-payload timeout.
//
// state      | meaning
// IN_IDLE    | waiting for a stream word
// IN_ESC_ACK | escape captured, acknowledging it
// IN_ESC     | waiting for the payload word, timer running
// IN_PUSH    | writing {type,word}; stalls while the FIFO is full
// OUT_IDLE   | waiting for a FIFO entry
// OUT_REQ    | strobing mil_request
// OUT_WAIT   | waiting for mil_done, then popping
module mil_esc_stream_decoder
    import mil_esc_stream_decoder_pkg::*;
#(
    parameter int          DW          = 16,
    parameter logic [DW-1:0] ESC_BASE  = DW'(ESC_BASE_DEFAULT),
    parameter int          DEPTH       = 8,
    parameter int          ESC_TIMEOUT = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_request_i,
    input  logic [DW-1:0]              in_data_i,
    output logic                       in_done_o,
    output logic                       mil_request_o,
    output logic [1:0]                 mil_type_o,
    output logic [DW-1:0]              mil_word_o,
    input  logic                       mil_done_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       esc_timeout_o
);
    localparam int TW = (ESC_TIMEOUT > 0) ? $clog2(ESC_TIMEOUT+1) : 1;
    localparam logic [TW-1:0] TLAST = (ESC_TIMEOUT > 0) ? TW'(ESC_TIMEOUT-1) : '0;

    in_state_e     in_state_q, in_state_d;
    out_state_e    out_state_q, out_state_d;
    word_type_e    type_q, type_d;
    logic [DW-1:0] word_q, word_d;
    logic [TW-1:0] timer_q, timer_d;
    word_type_e    mil_type_q, mil_type_d;
    logic [DW-1:0] mil_word_q, mil_word_d;

    logic          push, pop, fifo_full, fifo_empty, is_esc;
    logic [DW+1:0] fifo_dout;

    assign is_esc = (in_data_i[DW-1:2] == ESC_BASE[DW-1:2]);

    mil_word_fifo #(.W(DW+2), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .din_i   ({type_q, word_q}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State and datapath registers for both FSMs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_state_q  <= IN_IDLE;
            type_q      <= WDATA;
            word_q      <= '0;
            timer_q     <= '0;
            out_state_q <= OUT_IDLE;
            mil_type_q  <= WDATA;
            mil_word_q  <= '0;
        end else begin
            in_state_q  <= in_state_d;
            type_q      <= type_d;
            word_q      <= word_d;
            timer_q     <= timer_d;
            out_state_q <= out_state_d;
            mil_type_q  <= mil_type_d;
            mil_word_q  <= mil_word_d;
        end
    end

    // Input FSM: decode escapes, time out lone escapes, push into the FIFO.
    always_comb begin
        in_state_d    = in_state_q;
        type_d        = type_q;
        word_d        = word_q;
        timer_d       = timer_q;
        push          = 1'b0;
        in_done_o     = 1'b0;
        esc_timeout_o = 1'b0;
        case (in_state_q)
            IN_IDLE: begin
                if (in_request_i) begin
                    word_d = in_data_i;
                    if (is_esc) begin
                        type_d     = esc_to_type(esc_code_e'(in_data_i[1:0]));
                        timer_d    = '0;
                        in_state_d = IN_ESC_ACK;
                    end else begin
                        type_d     = WDATA;
                        in_state_d = IN_PUSH;
                    end
                end
            end
            IN_ESC_ACK: begin
                in_done_o  = 1'b1;
                in_state_d = IN_ESC;
            end
            IN_ESC: begin
                // A strobe arriving on the expiry cycle still counts as payload.
                if (in_request_i) begin
                    word_d     = in_data_i;
                    in_state_d = IN_PUSH;
                end else if ((ESC_TIMEOUT != 0) && (timer_q == TLAST)) begin
                    esc_timeout_o = 1'b1;
                    type_d        = WDATA;
                    in_state_d    = IN_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            IN_PUSH: begin
                if (!fifo_full) begin
                    push       = 1'b1;
                    in_done_o  = 1'b1;
                    in_state_d = IN_IDLE;
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    // Output FSM: present the FIFO head to the MIL transmitter, pop on done.
    always_comb begin
        out_state_d   = out_state_q;
        mil_type_d    = mil_type_q;
        mil_word_d    = mil_word_q;
        pop           = 1'b0;
        mil_request_o = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (!fifo_empty) begin
                    mil_type_d  = word_type_e'(fifo_dout[DW+1:DW]);
                    mil_word_d  = fifo_dout[DW-1:0];
                    out_state_d = OUT_REQ;
                end
            end
            OUT_REQ: begin
                mil_request_o = 1'b1;
                out_state_d   = OUT_WAIT;
            end
            OUT_WAIT: begin
                if (mil_done_i) begin
                    pop         = 1'b1;
                    out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    assign mil_type_o = mil_type_q;
    assign mil_word_o = mil_word_q;

endmodule

// File: tb/tb_mil_esc_stream_decoder.sv
// Scoreboard bench for mil_esc_stream_decoder: expected MIL words are queued
// as stream words are driven and compared when mil_request appears.
module tb_mil_esc_stream_decoder;
    localparam int DW          = 16;
    localparam int DEPTH       = 8;
    localparam int ESC_TIMEOUT = 1024;
    localparam logic [1:0] T_ERR = 2'd0, T_CMD = 2'd1, T_STS = 2'd2, T_DAT = 2'd3;

    logic          clk, rst_n;
    logic          in_request, in_done, mil_request, mil_done, esc_timeout;
    logic [DW-1:0] in_data, mil_word;
    logic [1:0]    mil_type;
    logic [3:0]    level;

    logic [17:0]   sb[$];
    bit            hold;
    int            n_vec = 0;
    int            n_err = 0;

    mil_esc_stream_decoder #(.DW(DW), .DEPTH(DEPTH), .ESC_TIMEOUT(ESC_TIMEOUT)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_request_i  (in_request),
        .in_data_i     (in_data),
        .in_done_o     (in_done),
        .mil_request_o (mil_request),
        .mil_type_o    (mil_type),
        .mil_word_o    (mil_word),
        .mil_done_i    (mil_done),
        .level_o       (level),
        .esc_timeout_o (esc_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one stream word and wait for its in_done; leaves the DUT ready.
    task automatic send_word(input logic [15:0] w);
        int n;
        in_request = 1'b1;
        in_data    = w;
        @(negedge clk);
        in_request = 1'b0;
        n = 1;
        while (in_done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_done_latency", n, 1);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((level != 0 || sb.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(level), 0);
        repeat (6) @(negedge clk);
    endtask

    // MIL transmitter model: compare each request against the scoreboard, answer with mil_done.
    initial begin
        logic [17:0] e;
        mil_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mil_request === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_request", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("mil_type", 32'(mil_type), 32'(e[17:16]));
                    chk("mil_word", 32'(mil_word), 32'(e[15:0]));
                end
                while (hold) @(negedge clk);
                @(negedge clk);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                mil_done = 1'b1;
                @(negedge clk);
                mil_done = 1'b0;
            end
        end
    end

    initial begin
        int          n, fired;
        bit          seen;
        logic [15:0] w;

        rst_n = 1'b0; in_request = 1'b0; in_data = '0; hold = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_done", 32'(in_done), 0);
        chk("rst_mil_request", 32'(mil_request), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_esc_timeout", 32'(esc_timeout), 0);
        chk("rst_mil_type", 32'(mil_type), 32'(T_DAT));
        chk("rst_mil_word", 32'(mil_word), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain word straight through.
        sb.push_back({T_DAT, 16'h1234});
        send_word(16'h1234);
        chk("t1_level_one", 32'(level), 1);
        drain("t1_drain");

        // Escaped command word.
        send_word(16'hFFA1);
        sb.push_back({T_CMD, 16'h0C21});
        send_word(16'h0C21);
        drain("t2_drain");

        // Escaped data whose payload looks like an escape.
        send_word(16'hFFA3);
        sb.push_back({T_DAT, 16'hFFA2});
        send_word(16'hFFA2);
        drain("t3_drain");

        // Other escape codes.
        send_word(16'hFFA0);
        sb.push_back({T_ERR, 16'h00E0});
        send_word(16'h00E0);
        send_word(16'hFFA2);
        sb.push_back({T_STS, 16'h5A5A});
        send_word(16'h5A5A);
        drain("t3b_drain");

        // Fill the FIFO with the transmitter stalled; the 9th word is held off.
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 16'h0100 + 16'(i);
            sb.push_back({T_DAT, w});
            send_word(w);
        end
        chk("bp_level_full", 32'(level), 8);
        sb.push_back({T_DAT, 16'h0108});
        in_request = 1'b1;
        in_data    = 16'h0108;
        @(negedge clk);
        in_request = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            if (in_done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("bp_done_withheld", 32'(seen), 0);
        chk("bp_level_still_full", 32'(level), 8);
        hold = 1'b0;
        n = 0;
        while (in_done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_released", 32'(in_done), 1);
        @(negedge clk);
        drain("bp_drain");

        // Lone escape times out without writing the FIFO.
        send_word(16'hFFA2);
        fired = -1;
        for (int k = 0; k < ESC_TIMEOUT + 100; k++) begin
            if (esc_timeout === 1'b1) begin
                fired = k;
                break;
            end
            @(negedge clk);
        end
        chk("to_cycle", 32'(fired), 32'(ESC_TIMEOUT - 1));
        @(negedge clk);
        chk("to_no_write", 32'(level), 0);
        chk("to_single_pulse", 32'(esc_timeout), 0);
        sb.push_back({T_DAT, 16'h0005});
        send_word(16'h0005);
        drain("to_drain");

        // Reset mid-escape with three queued words.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = 16'h0A00 + 16'(i);
            sb.push_back({T_DAT, w});
            send_word(w);
        end
        send_word(16'hFFA1);
        chk("rs_level_before", 32'(level), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_level", 32'(level), 0);
        chk("rs_mil_request", 32'(mil_request), 0);
        chk("rs_in_done", 32'(in_done), 0);
        chk("rs_esc_timeout", 32'(esc_timeout), 0);
        chk("rs_mil_type", 32'(mil_type), 32'(T_DAT));
        chk("rs_mil_word", 32'(mil_word), 0);
        sb.delete();
        hold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (in_done === 1'b1 || mil_request === 1'b1 || level != 0) seen = 1'b1;
        end
        chk("rs_no_spurious", 32'(seen), 0);
        sb.push_back({T_DAT, 16'h0042});
        send_word(16'h0042);
        drain("rs_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
